// File: rtl/sha2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// sha2_pkg : SHA-256/224 constants, FSM state type and round helpers
// Revision : 1.0
// ----------------------------------------------------------------------
package sha2_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha2_round.sv
`default_nettype none
// ----------------------------------------------------------------------
// sha2_round : one combinational SHA-2 compression round, a..h packed a-first
// Revision   : 1.0
// ----------------------------------------------------------------------
module sha2_round
  import sha2_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] state_o
);
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;
  assign t1 = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = bsig0(a) + maj(a, b, c);
  assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule
`default_nettype wire

// File: rtl/sha2_stream_core.sv
`default_nettype none
// ----------------------------------------------------------------------
// sha2_stream_core : block-streaming SHA-256/224 core, ROUNDS_PER_CYCLE rounds/clk
// Revision         : 1.0
// ----------------------------------------------------------------------
module sha2_stream_core
  import sha2_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         mode224,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
  output logic         busy
);
  localparam int         c_R    = ROUNDS_PER_CYCLE;
  localparam logic [5:0] c_STEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] c_LAST = 6'(64 - ROUNDS_PER_CYCLE);

  if (!(c_R == 1 || c_R == 2 || c_R == 4)) begin : g_bad_rpc
    $error("sha2_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t       state_q;
  logic [255:0] h_q;
  logic [255:0] work_q;
  logic [31:0]  win_q [16];
  logic [5:0]   rnd_q;
  logic         open_q, last_q, mode_q;
  logic         blk_ready_q, dig_valid_q, busy_q;

  // Window extended by the c_R words this cycle needs; new words may feed each other.
  logic [31:0]  ext_d [16+c_R];
  wire  [c_R:0][255:0] chain_d;
  logic         first_sel;
  logic [255:0] iv_sel;

  always_comb begin
    for (int i = 0; i < 16; i++) ext_d[i] = win_q[i];
    for (int j = 0; j < c_R; j++)
      ext_d[16+j] = ssig1(ext_d[14+j]) + ext_d[9+j] + ssig0(ext_d[1+j]) + ext_d[j];
  end

  assign chain_d[0] = work_q;

  for (genvar j = 0; j < c_R; j++) begin : g_round
    sha2_round u_round (
      .state_i (chain_d[j]),
      .k_i     (K[rnd_q + 6'(j)]),
      .w_i     (ext_d[j]),
      .state_o (chain_d[j+1])
    );
  end

  assign first_sel = blk_first || !open_q;
  assign iv_sel    = mode224 ? IV224 : IV256;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_ready_q <= 1'b1;
      dig_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      h_q         <= '0;
      work_q      <= '0;
      rnd_q       <= '0;
      open_q      <= 1'b0;
      last_q      <= 1'b0;
      mode_q      <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (blk_valid && blk_ready_q) begin
            for (int i = 0; i < 16; i++) win_q[i] <= blk_data[511-32*i -: 32];
            if (first_sel) begin
              h_q    <= iv_sel;
              work_q <= iv_sel;
              mode_q <= mode224;
            end else begin
              work_q <= h_q;
            end
            open_q      <= 1'b1;
            last_q      <= blk_last;
            rnd_q       <= '0;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ROUND;
          end
        end
        ROUND: begin
          work_q <= chain_d[c_R];
          for (int i = 0; i < 16; i++) win_q[i] <= ext_d[i+c_R];
          rnd_q <= rnd_q + c_STEP;
          if (rnd_q == c_LAST) state_q <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++)
            h_q[255-32*i -: 32] <= h_q[255-32*i -: 32] + work_q[255-32*i -: 32];
          if (last_q) begin
            dig_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        OUT: begin
          if (dig_ready) begin
            dig_valid_q <= 1'b0;
            open_q      <= 1'b0;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign blk_ready = blk_ready_q;
  assign dig_valid = dig_valid_q;
  assign busy      = busy_q;
  assign digest    = mode_q ? {h_q[255:32], 32'h0} : h_q;

endmodule
`default_nettype wire

// File: doc/sha2_stream_core.md
SHA2_STREAM_CORE -- requirements
Module: sha2_stream_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, number of compression rounds per clock; legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port blk_valid, input, 1, a 512-bit message block is offered.
REQ-005 SHALL have port blk_ready, output, 1, core accepts a block this cycle.
REQ-006 SHALL have port blk_data, input, 512, block with W0 at [511:480] and W15 at [31:0].
REQ-007 SHALL have port blk_first, input, 1, block starts a new message.
REQ-008 SHALL have port blk_last, input, 1, block ends the message.
REQ-009 SHALL have port mode224, input, 1, selects SHA-224 (1) or SHA-256 (0); sampled only on a first block.
REQ-010 SHALL have port dig_valid, output, 1, digest is available.
REQ-011 SHALL have port dig_ready, input, 1, consumer takes the digest.
REQ-012 SHALL have port digest, output, 256, H0 at [255:224].
REQ-013 SHALL have port busy, output, 1, high in every state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, ROUND, FINAL and OUT; blk_ready = (state==IDLE).
REQ-015 SHALL, on accept (blk_valid&&blk_ready), capture blk_data, load a..h from the chaining H, clear the round counter and enter ROUND.
REQ-016 SHALL load chaining H from the IV selected by mode224 when blk_first=1 or no message is open, and otherwise use the stored H.
REQ-017 SHALL perform ROUNDS_PER_CYCLE rounds per ROUND cycle, so ROUND lasts N=64/ROUNDS_PER_CYCLE cycles and the round counter steps by ROUNDS_PER_CYCLE.
REQ-018 SHALL keep the message schedule in a 16-word sliding window: rounds 0-15 use block words, and later rounds use W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16], producing ROUNDS_PER_CYCLE new words per cycle.
REQ-019 SHALL perform all additions modulo 2^32, with rotations per FIPS 180-4.
REQ-020 SHALL, in FINAL (1 cycle), set H_i += working variable, then go to OUT if blk_last was set on that block and to IDLE otherwise.
REQ-021 SHALL give a latency from the accept edge to the first cycle of dig_valid (or of blk_ready for a non-last block) of N+1 cycles.
REQ-022 SHALL, in OUT, hold dig_valid=1 and digest stable until dig_ready=1, then clear dig_valid, close the message and return to IDLE on the next cycle.
REQ-023 SHALL output digest = H0..H7 in SHA-256 mode and {H0..H6, 32'h0} in SHA-224 mode.
REQ-024 SHALL treat a block with blk_first=blk_last=1 as a one-block message.
REQ-025 SHALL, if blk_first=1 arrives while a message is open, discard the open chain and restart from the IV.
REQ-026 SHALL ignore blk_valid outside IDLE, so blocks offered during OUT wait.
REQ-027 SHALL hold the latched mode for the whole message and ignore mode224 on non-first blocks.
REQ-028 SHALL cause an elaboration error for an illegal ROUNDS_PER_CYCLE.

Reset
REQ-029 SHALL, on rst, set state=IDLE, blk_ready=1 after release, dig_valid=0, busy=0, digest=0, round counter=0, and no message open.
REQ-030 SHALL, on rst mid-ROUND/FINAL/OUT, abort immediately with no digest produced; the next block is treated as a first block.

Structure
REQ-031 SHALL place in package sha2_pkg: the K[0:63] table, IV256, IV224, the state enum and the sigma/ch/maj functions.
REQ-032 SHALL implement one combinational round as sub-module sha2_round, instantiated ROUNDS_PER_CYCLE times in a chain.

Verification
REQ-033 SHALL cover: "abc" padded, single block, SHA-256 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-034 SHALL cover: "abc", mode224=1 -> digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
REQ-035 SHALL cover: the 56-char "abcdbcdecdef...nopq" two-block message -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, with blk_ready low for 65 cycles between the blocks (R=1).
REQ-036 SHALL cover: ROUNDS_PER_CYCLE=1/2/4 with "abc" -> dig_valid 65/33/17 cycles after accept, and identical digests.
REQ-037 SHALL cover: dig_ready held low for 10 cycles -> dig_valid and digest stable, blk_ready=0 throughout, IDLE one cycle after dig_ready.
REQ-038 SHALL cover: rst pulse at round 30 of block 1 of a two-block message, then resending "abc" -> no dig_valid before the resend, and the correct "abc" digest after it.
